bcd_scan_mux: RTL and testbench



---
 rtl/bcd_scan_if.sv | 26 ++
 rtl/bcd_scan_mux.sv | 125 ++++++++++++
 tb/tb_bcd_scan_mux.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_if.sv
// Scan-driver bus: BCD value in, decoder nibble plus digit enables out.
//   digits     : 4-digit BCD value, [3:0] = digit0 ... [15:12] = digit3
//   A/B/C/D    : nibble to the 7-segment decoder, A = MSB
//   dig_en     : one-hot digit common enable
//   blank      : no digit lit this cycle
//   frame_tick : one-cycle pulse at the start of each frame
interface bcd_scan_if;
  logic [15:0] digits;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic [3:0]  dig_en;
  logic        blank;
  logic        frame_tick;

  modport master (
    output digits,
    input  A, B, C, D, dig_en, blank, frame_tick
  );

  modport slave (
    input  digits,
    output A, B, C, D, dig_en, blank, frame_tick
  );
endinterface

// File: rtl/bcd_scan_mux.sv
// Four-digit time-multiplexed scan driver for a BCD-to-7-segment decoder.
// Each slot lasts DIV cycles: one dead cycle, then DIV-1 lit cycles.
// The displayed value is captured into a shadow register only at frame
// boundaries, so a frame never mixes two values.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_scan_if (digits in; A..D, dig_en, blank,
//           frame_tick out, all registered)
module bcd_scan_mux #(
  parameter int unsigned DIV      = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  bcd_scan_if.slave bus
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned VAL_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [SLOT_W-1:0] slot_q,       slot_d;
  logic [VAL_W-1:0]  shadow_q,     shadow_d;
  logic [NIB_W-1:0]  abcd_q,       abcd_d;
  logic [3:0]        dig_en_q,     dig_en_d;
  logic              blank_q,      blank_d;
  logic              frame_tick_q, frame_tick_d;

  logic [NIB_W-1:0]  nib_c;
  logic              upper_zero_c;
  logic              suppress_c;
  logic              slot_end_c;
  logic              frame_end_c;

  // Next-state: prescaler, slot stepping, frame capture and registered outputs.
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    frame_tick_d = 1'b0;
    nib_c        = '0;
    upper_zero_c = 1'b0;
    abcd_d       = '0;
    dig_en_d     = '0;
    blank_d      = 1'b1;

    slot_end_c  = (cnt_q == CNT_MAX);
    frame_end_c = slot_end_c && (slot_q == SLOT_W'(3));

    if (slot_end_c) begin
      cnt_d  = '0;
      slot_d = slot_q + SLOT_W'(1);
    end

    if (frame_end_c) begin
      shadow_d     = bus.digits;
      frame_tick_d = 1'b1;
    end

    // upper_zero_c: this digit and every more-significant digit are zero;
    // invalid codes are nonzero so they never trigger blanking.
    unique case (slot_q)
      2'd0: begin
        nib_c        = shadow_q[3:0];
        upper_zero_c = 1'b0;
      end
      2'd1: begin
        nib_c        = shadow_q[7:4];
        upper_zero_c = (shadow_q[15:4] == 12'd0);
      end
      2'd2: begin
        nib_c        = shadow_q[11:8];
        upper_zero_c = (shadow_q[15:8] == 8'd0);
      end
      default: begin
        nib_c        = shadow_q[15:12];
        upper_zero_c = (shadow_q[15:12] == 4'd0);
      end
    endcase

    suppress_c = (cnt_q == '0) ||
                 (nib_c > NIB_W'(9)) ||
                 (BLANK_LZ && upper_zero_c);

    if (!suppress_c) begin
      abcd_d   = nib_c;
      dig_en_d = 4'(4'b0001 << slot_q);
      blank_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      slot_q       <= '0;
      shadow_q     <= '0;
      abcd_q       <= '0;
      dig_en_q     <= '0;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      abcd_q       <= abcd_d;
      dig_en_q     <= dig_en_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.A          = abcd_q[3];
  assign bus.B          = abcd_q[2];
  assign bus.C          = abcd_q[1];
  assign bus.D          = abcd_q[0];
  assign bus.dig_en     = dig_en_q;
  assign bus.blank      = blank_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Bench for bcd_scan_mux: two instances (zero blanking on and off) share one
// digits stimulus; a per-cycle model check plus literal spot checks.
module tb_bcd_scan_mux;

  localparam int unsigned DIV = 4;
  localparam int unsigned FRAME = 4 * DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] dig;

  int n_tests;
  int n_fail;

  bcd_scan_if if_lz ();
  bcd_scan_if if_nz ();

  assign if_lz.digits = dig;
  assign if_nz.digits = dig;

  bcd_scan_mux #(.DIV(DIV), .BLANK_LZ(1'b1)) dut_lz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_lz.slave)
  );

  bcd_scan_mux #(.DIV(DIV), .BLANK_LZ(1'b0)) dut_nz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_nz.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What a display shows: digit s of value v at in-slot position c.
  // Returns {dig_en, nibble, blank}.
  function automatic logic [8:0] shown(input logic [15:0] v, input int s, input int c, input bit lz);
    int top;
    logic [15:0] t;
    logic [3:0] d;
    top = 0;
    for (int i = 0; i < 4; i++) begin
      t = v >> (4 * i);
      if (t[3:0] != 4'd0) top = i;
    end
    t = v >> (4 * s);
    d = t[3:0];
    if (c == 0 || d > 4'd9 || (lz && s > top)) return {4'b0000, 4'd0, 1'b1};
    return {4'(1 << s), d, 1'b0};
  endfunction

  // Model: edges since reset release drive slot/position; value latched each frame.
  int          e_q;
  logic [15:0] m_shadow;
  logic [8:0]  exp_lz;
  logic [8:0]  exp_nz;
  logic        exp_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= 0;
      m_shadow <= 16'h0000;
      exp_lz   <= {4'b0000, 4'd0, 1'b1};
      exp_nz   <= {4'b0000, 4'd0, 1'b1};
      exp_tick <= 1'b0;
    end else begin
      exp_lz   <= shown(m_shadow, (e_q / DIV) % 4, e_q % DIV, 1'b1);
      exp_nz   <= shown(m_shadow, (e_q / DIV) % 4, e_q % DIV, 1'b0);
      exp_tick <= ((e_q + 1) % FRAME) == 0;
      if (((e_q + 1) % FRAME) == 0) m_shadow <= dig;
      e_q      <= e_q + 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("lz_dig_en", 16'(if_lz.dig_en), 16'(exp_lz[8:5]));
    check("lz_abcd", 16'({if_lz.A, if_lz.B, if_lz.C, if_lz.D}), 16'(exp_lz[4:1]));
    check("lz_blank", 16'(if_lz.blank), 16'(exp_lz[0]));
    check("lz_tick", 16'(if_lz.frame_tick), 16'(exp_tick));
    check("nz_dig_en", 16'(if_nz.dig_en), 16'(exp_nz[8:5]));
    check("nz_abcd", 16'({if_nz.A, if_nz.B, if_nz.C, if_nz.D}), 16'(exp_nz[4:1]));
    check("nz_blank", 16'(if_nz.blank), 16'(exp_nz[0]));
    check("nz_tick", 16'(if_nz.frame_tick), 16'(exp_tick));
    check("lz_onehot", 16'($countones(if_lz.dig_en) > 1), 16'd0);
    check("nz_onehot", 16'($countones(if_nz.dig_en) > 1), 16'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit_lz(input string name, input logic [3:0] en, input logic [3:0] n, input logic bl);
    check({name, "_en"}, 16'(if_lz.dig_en), 16'(en));
    check({name, "_abcd"}, 16'({if_lz.A, if_lz.B, if_lz.C, if_lz.D}), 16'(n));
    check({name, "_blank"}, 16'(if_lz.blank), 16'(bl));
  endtask

  task automatic lit_nz(input string name, input logic [3:0] en, input logic [3:0] n, input logic bl);
    check({name, "_en"}, 16'(if_nz.dig_en), 16'(en));
    check({name, "_abcd"}, 16'({if_nz.A, if_nz.B, if_nz.C, if_nz.D}), 16'(n));
    check({name, "_blank"}, 16'(if_nz.blank), 16'(bl));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    dig     = 16'h9999;

    tick(3);
    lit_lz("rst", 4'b0000, 4'd0, 1'b1);
    check("rst_tick", 16'(if_lz.frame_tick), 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    dig   = 16'h1234;

    // Before the first load the shadow is zero: digit0 shows 0.
    tick(2);  lit_lz("pre_load", 4'b0001, 4'd0, 1'b0);            // e2
    tick(14); check("tick16", 16'(if_lz.frame_tick), 16'd1);      // e16
    tick(1);  lit_lz("dead17", 4'b0000, 4'd0, 1'b1);              // e17
    check("tick17", 16'(if_lz.frame_tick), 16'd0);
    tick(1);  lit_lz("s0_1234", 4'b0001, 4'd4, 1'b0);             // e18
    tick(4);  lit_lz("s1_1234", 4'b0010, 4'd3, 1'b0);             // e22
    tick(4);  lit_lz("s2_1234", 4'b0100, 4'd2, 1'b0);             // e26
    tick(4);  lit_lz("s3_1234", 4'b1000, 4'd1, 1'b0);             // e30
    tick(2);  dig = 16'h0050;                                     // e32, loads at e48

    tick(18); lit_lz("s0_0050", 4'b0001, 4'd0, 1'b0);             // e50
    tick(4);  lit_lz("s1_0050", 4'b0010, 4'd5, 1'b0);             // e54
    tick(4);  lit_lz("s2_0050", 4'b0000, 4'd0, 1'b1);             // e58
    lit_nz("s2_0050_nz", 4'b0100, 4'd0, 1'b0);
    dig = 16'h0000;                                               // loads at e64

    tick(8);  lit_lz("s0_0000", 4'b0001, 4'd0, 1'b0);             // e66
    tick(4);  lit_lz("s1_0000", 4'b0000, 4'd0, 1'b1);             // e70
    lit_nz("s1_0000_nz", 4'b0010, 4'd0, 1'b0);
    dig = 16'h12A4;                                               // loads at e80

    tick(12); lit_lz("s0_12a4", 4'b0001, 4'd4, 1'b0);             // e82
    tick(4);  lit_lz("s1_12a4", 4'b0000, 4'd0, 1'b1);             // e86
    tick(4);  lit_lz("s2_12a4", 4'b0100, 4'd2, 1'b0);             // e90
    tick(4);  lit_lz("s3_12a4", 4'b1000, 4'd1, 1'b0);             // e94
    dig = 16'h1111;                                               // loads at e96

    tick(12); dig = 16'h2222;                                     // e106, slot2 of frame
    tick(4);  lit_lz("tear_s3", 4'b1000, 4'd1, 1'b0);             // e110
    tick(4);  lit_lz("new_s0", 4'b0001, 4'd2, 1'b0);              // e114
    tick(8);  lit_lz("pre_rst_s2", 4'b0100, 4'd2, 1'b0);          // e122

    // Asynchronous reset in the middle of a lit cycle.
    #1 rst_n = 1'b0;
    #1 lit_lz("async_rst", 4'b0000, 4'd0, 1'b1);
    check("async_rst_tick", 16'(if_lz.frame_tick), 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    tick(2);  lit_lz("post_rst_s0", 4'b0001, 4'd0, 1'b0);         // e2
    tick(4);  lit_lz("post_rst_s1", 4'b0000, 4'd0, 1'b1);         // e6
    tick(12); lit_lz("post_rst_load", 4'b0001, 4'd2, 1'b0);       // e18

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
